// File: rtl/mmio_port_bank.sv
// Memory-mapped window of NUM_PORTS bidirectional I/O ports plus one status word.
// Accesses outside the window are forwarded untouched to data memory.
module mmio_port_bank #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 16,
  parameter int NUM_PORTS = 4,
  parameter int BASE_ADDR = 251
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic                       i_wr_en,
  input  logic                       i_rd_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic [WIDTH-1:0]           i_mem_rdata,
  output logic                       o_mem_wr_en,
  output logic [WIDTH-1:0]           o_rd_data,
  input  logic [NUM_PORTS*WIDTH-1:0] i_io_in,
  input  logic [NUM_PORTS-1:0]       i_io_in_valid,
  output logic [NUM_PORTS-1:0]       o_io_in_full,
  output logic [NUM_PORTS*WIDTH-1:0] o_io_out,
  output logic [NUM_PORTS-1:0]       o_io_out_strobe
);

  localparam int STAT_ADDR = BASE_ADDR + NUM_PORTS;

  logic [NUM_PORTS-1:0] w_port_hit;
  logic                 w_stat_hit;
  logic                 w_hit;
  logic                 w_stat_rd;
  logic [NUM_PORTS-1:0] w_port_rd;
  logic [NUM_PORTS-1:0] w_port_wr;

  logic [NUM_PORTS-1:0] r_full;
  logic [NUM_PORTS-1:0] w_full_next;
  logic [NUM_PORTS-1:0] w_capture;
  logic [NUM_PORTS-1:0] w_ovr_set;
  logic [NUM_PORTS-1:0] r_ovr;
  logic [NUM_PORTS-1:0] r_strobe;
  logic [WIDTH-1:0]     r_in  [NUM_PORTS];
  logic [WIDTH-1:0]     r_out [NUM_PORTS];
  logic [WIDTH-1:0]     w_status;

  // Compare one bit wider than the bus so the window never wraps around zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_port_hit[gi] = ({1'b0, i_addr} == (ADDR_W+1)'(BASE_ADDR + gi));
      assign o_io_out[gi*WIDTH +: WIDTH] = r_out[gi];
    end
  endgenerate

  assign w_stat_hit  = ({1'b0, i_addr} == (ADDR_W+1)'(STAT_ADDR));
  assign w_hit       = (|w_port_hit) | w_stat_hit;
  assign w_stat_rd   = i_rd_en & w_stat_hit;
  assign w_port_rd   = w_port_hit & {NUM_PORTS{i_rd_en}};
  assign w_port_wr   = w_port_hit & {NUM_PORTS{i_wr_en}};
  assign o_mem_wr_en = i_wr_en & ~w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_full <= '0;
    else          r_full <= w_full_next;
  end

  always_comb begin
    w_full_next = r_full;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!r_full[i]) begin
        if (i_io_in_valid[i]) w_full_next[i] = 1'b1;
      end else if (w_port_rd[i] && !i_io_in_valid[i]) begin
        w_full_next[i] = 1'b0;
      end
    end
  end

  // A read coinciding with a new word hands the old word out and refills, so no overrun.
  always_comb begin
    w_capture = '0;
    w_ovr_set = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!r_full[i]) begin
        w_capture[i] = i_io_in_valid[i];
      end else begin
        w_capture[i] = i_io_in_valid[i] & w_port_rd[i];
        w_ovr_set[i] = i_io_in_valid[i] & ~w_port_rd[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovr    <= '0;
      r_strobe <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_in[i]  <= '0;
        r_out[i] <= '0;
      end
    end else begin
      r_ovr    <= w_ovr_set | (r_ovr & ~{NUM_PORTS{w_stat_rd}});
      r_strobe <= w_port_wr;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_capture[i]) r_in[i]  <= i_io_in[i*WIDTH +: WIDTH];
        if (w_port_wr[i]) r_out[i] <= i_wr_data;
      end
    end
  end

  always_comb begin
    w_status = '0;
    w_status[2*NUM_PORTS-1:0] = {r_ovr, r_full};
  end

  always_comb begin
    o_rd_data = i_mem_rdata;
    if (w_stat_hit) o_rd_data = w_status;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_port_hit[i]) o_rd_data = r_in[i];
    end
  end

  assign o_io_in_full    = r_full;
  assign o_io_out_strobe = r_strobe;

endmodule

// File: doc/mmio_port_bank.md
# mmio_port_bank

Parametrised memory-mapped I/O bank between the datapath's memory port and the board pins. It replaces the single hard-wired I/O address with a window of NUM_PORTS bidirectional ports plus one status word. Port writes land in registered outputs with a one-cycle strobe; inputs are captured on a valid pulse, flagged full until read, and overrun-tracked. Accesses outside the window pass straight through to data memory.

## Interface
- WIDTH, 16, data word width
- ADDR_W, 16, address width
- NUM_PORTS, 4, number of I/O ports (1..8; 2*NUM_PORTS <= WIDTH)
- BASE_ADDR, 251, address of port 0; port i at BASE_ADDR+i, status at BASE_ADDR+NUM_PORTS (default window 251..255)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  access address from datapath
- wr_en  in  1  datapath write request (the incoming MemWrite)
- rd_en  in  1  datapath read qualifier; one cycle high per architectural load
- wr_data  in  WIDTH  store data
- mem_rdata  in  WIDTH  read data from data memory
- mem_wr_en  out  1  write enable forwarded to data memory
- rd_data  out  WIDTH  read data to datapath
- io_in  in  NUM_PORTS*WIDTH  port input data, port i at [i*WIDTH +: WIDTH], synchronous to clock
- io_in_valid  in  NUM_PORTS  single-cycle capture pulse per port
- io_in_full  out  NUM_PORTS  captured data unread
- io_out  out  NUM_PORTS*WIDTH  registered port output data
- io_out_strobe  out  NUM_PORTS  one-cycle pulse after a port write

## Operation
- Window hit: addr in [BASE_ADDR, BASE_ADDR+NUM_PORTS]. port_hit(i): addr == BASE_ADDR+i. stat_hit: addr == BASE_ADDR+NUM_PORTS.
- mem_wr_en = wr_en & ~hit (combinational). Memory is never written inside the window.
- rd_data (combinational): port_hit(i) -> in_reg[i]; stat_hit -> {zeros, ovr[NUM_PORTS-1:0], full[NUM_PORTS-1:0]}; otherwise mem_rdata.
- Port write: wr_en & port_hit(i) -> out_reg[i] <= wr_data; strobe[i] <= 1 for next cycle only. Status write: no effect.
- Per-port input state machine, two states. EMPTY (full=0): valid -> in_reg <= io_in slice, go FULL. FULL (full=1): rd_en & port_hit -> go EMPTY; valid without that read -> set ovr[i], keep in_reg, stay FULL.
- Same-cycle valid and read of a FULL port: rd_data returns the old in_reg. The new word is captured, the port stays FULL, and ovr is not set.
- Read of an EMPTY port returns the last captured word (stale). No state change.
- Status read (rd_en & stat_hit) clears all ovr bits. An overrun event in the same cycle wins, leaving that bit set. full bits are unaffected by status reads.
- wr_en and rd_en both high: both actions apply independently.
- Addresses above BASE_ADDR+NUM_PORTS, or below BASE_ADDR, are plain memory. No wrap-around.

## Timing
- Reset (reset low, asynchronous): out_reg, in_reg, full, ovr and strobe all 0. This gives io_out=0, io_out_strobe=0 and io_in_full=0 immediately. Released synchronously on the next clock edge with reset high.
- Reset mid-operation: all captured data and flags are lost. No pending strobe is emitted.
- Write latency: io_out and io_out_strobe are updated at the first rising edge with wr_en & hit. The strobe stays high exactly one cycle; back-to-back writes give a continuous strobe.
- Capture latency: in_reg and io_in_full are updated at the edge sampling io_in_valid. The data is readable in the following cycle.
- Read path: zero-cycle combinational. Flag clears take effect at the edge that ends the read cycle.
- mem_wr_en: zero-cycle combinational from wr_en/addr.

## Test plan
- Reset then idle: io_out=0, io_in_full=0, io_out_strobe=0; status read at 255 -> rd_data=0x0000.
- Write 0xBEEF to 252 -> mem_wr_en=0, io_out[31:16]=0xBEEF after the edge, io_out_strobe=4'b0010 for one cycle. Write 0x1234 to 100 -> mem_wr_en=1, io_out unchanged.
- Pulse io_in_valid[0] with 0x00AA -> io_in_full[0]=1. Read 251 -> rd_data=0x00AA, full[0]=0 after the edge. Reread -> 0x00AA, full stays 0.
- Overrun: capture 0x0011 on port 3, then a second valid with 0x0022 and no read -> rd_data at 254 = 0x0011. Status = 0x0088. Status read clears to 0x0008.
- Simultaneous: port 1 FULL with 0x0005; read 252 in the same cycle as valid with 0x0006 -> rd_data=0x0005, then full[1]=1, ovr[1]=0, next read 0x0006.
- Assert reset low mid-stream with full=4'b1111 and io_out nonzero -> all outputs 0 before the next clock edge.
